// File: rtl/karat_mult_seq.sv
// karat_mult_seq: word-stream sequencer around the Karatsuba multiplier.
// Optional WAIT timeout: define KARAT_SEQ_TIMEOUT_EN.
module karat_mult_seq #(
    parameter int W_OP        = 1024,
    parameter int W_WORD      = 32,
    parameter int W_PROD      = 2 * W_OP,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_WORD-1:0] in_data,
    output logic [W_OP-1:0]   mul_x,
    output logic [W_OP-1:0]   mul_y,
    output logic              mul_en,
    input  logic              mul_finish,
    input  logic [W_PROD-1:0] mul_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_WORD-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err
);

    localparam int N_IN  = W_OP / W_WORD;
    localparam int N_OUT = W_PROD / W_WORD;
    localparam int CW    = $clog2(N_OUT);
    localparam logic [CW-1:0] LAST_IN  = CW'(N_IN - 1);
    localparam logic [CW-1:0] LAST_OUT = CW'(N_OUT - 1);

    if ((W_OP % W_WORD) != 0 || (W_PROD % W_WORD) != 0 || TIMEOUT_CYC < 1)
    begin : g_bad_cfg
        $error("karat_mult_seq: inconsistent parameters");
    end

    typedef enum logic [2:0] {
        S_LOAD_X,
        S_LOAD_Y,
        S_FIRE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [W_OP-1:0]   x_q, x_n;
    logic [W_OP-1:0]   y_q, y_n;
    logic [W_PROD-1:0] prod_q, prod_n;
    logic              en_q, en_n;

`ifdef KARAT_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] tcnt, tcnt_n;
    logic          err_q, err_n;
`endif

    // State, counters, operand/product registers and enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_LOAD_X;
            cnt    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            prod_q <= '0;
            en_q   <= 1'b0;
`ifdef KARAT_SEQ_TIMEOUT_EN
            tcnt   <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            x_q    <= x_n;
            y_q    <= y_n;
            prod_q <= prod_n;
            en_q   <= en_n;
`ifdef KARAT_SEQ_TIMEOUT_EN
            tcnt   <= tcnt_n;
            err_q  <= err_n;
`endif
        end
    end

    // Next-state and handshake outputs; one shared word counter serves load and drain.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        x_n       = x_q;
        y_n       = y_q;
        prod_n    = prod_q;
        en_n      = en_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b1;
        out_data  = prod_q[int'(cnt) * W_WORD +: W_WORD];
`ifdef KARAT_SEQ_TIMEOUT_EN
        tcnt_n    = '0;
        err_n     = err_q;
`endif
        unique case (state)
            S_LOAD_X: begin
                in_ready = 1'b1;
                busy     = (cnt != '0);
                if (in_valid) begin
                    x_n[int'(cnt) * W_WORD +: W_WORD] = in_data;
                    if (cnt == LAST_IN) begin
                        cnt_n   = '0;
                        state_n = S_LOAD_Y;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            S_LOAD_Y: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    y_n[int'(cnt) * W_WORD +: W_WORD] = in_data;
                    if (cnt == LAST_IN) begin
                        cnt_n   = '0;
                        state_n = S_FIRE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            S_FIRE: begin
                // A finish still high from the previous job must clear first.
                if (!mul_finish) begin
                    en_n    = 1'b1;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mul_finish) begin
                    prod_n  = mul_prod;
                    en_n    = 1'b0;
                    cnt_n   = '0;
                    state_n = S_DRAIN;
`ifdef KARAT_SEQ_TIMEOUT_EN
                end else if (tcnt == T_LAST) begin
                    prod_n  = '0;
                    en_n    = 1'b0;
                    err_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = S_DRAIN;
                end else begin
                    tcnt_n = tcnt + 1'b1;
`endif
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_last  = (cnt == LAST_OUT);
                if (out_ready) begin
                    if (cnt == LAST_OUT) begin
                        cnt_n   = '0;
                        state_n = S_LOAD_X;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_LOAD_X;
                cnt_n   = '0;
                en_n    = 1'b0;
            end
        endcase
    end

    assign mul_x  = x_q;
    assign mul_y  = y_q;
    assign mul_en = en_q;
`ifdef KARAT_SEQ_TIMEOUT_EN
    assign err    = err_q;
`else
    assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_karat_mult_seq.sv
// tb_karat_mult_seq: vector table, corner sequences and random jobs
// against a stub multiplier and an arithmetic product model.
module tb_karat_mult_seq;

    localparam int W_OP   = 1024;
    localparam int W_WORD = 32;
    localparam int W_PROD = 2 * W_OP;
    localparam int N_IN   = W_OP / W_WORD;
    localparam int N_OUT  = W_PROD / W_WORD;
    localparam int TO_CYC = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [W_WORD-1:0] in_data;
    logic [W_OP-1:0]   mul_x;
    logic [W_OP-1:0]   mul_y;
    logic              mul_en;
    logic              mul_finish;
    logic [W_PROD-1:0] mul_prod;
    logic              out_valid;
    logic              out_ready;
    logic [W_WORD-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_cyc;

    int stub_l = 5;
    int stub_hold = 0;
    bit stub_never = 1'b0;
    int scnt;
    int shold;

    int en_rises = 0;
    int stale_viol = 0;
    logic pen = 1'b0;
    logic pfin = 1'b0;

    karat_mult_seq #(
        .W_OP(W_OP), .W_WORD(W_WORD), .W_PROD(W_PROD), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mul_x(mul_x), .mul_y(mul_y), .mul_en(mul_en),
        .mul_finish(mul_finish), .mul_prod(mul_prod),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub multiplier: finish rises stub_l cycles after enable, then lingers
    // stub_hold extra cycles once enable has dropped.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_finish <= 1'b0;
            mul_prod   <= '0;
            scnt       <= 0;
            shold      <= 0;
        end else if (mul_en) begin
            if (!mul_finish) begin
                if (scnt + 1 >= stub_l && !stub_never) begin
                    mul_finish <= 1'b1;
                    mul_prod   <= {{W_OP{1'b0}}, mul_x} * {{W_OP{1'b0}}, mul_y};
                    scnt       <= 0;
                end else begin
                    scnt <= scnt + 1;
                end
            end
        end else if (mul_finish) begin
            if (shold >= stub_hold) begin
                mul_finish <= 1'b0;
                shold      <= 0;
            end else begin
                shold <= shold + 1;
            end
        end
    end

    // Enable must never rise out of a cycle in which finish was still high.
    always @(negedge clk) begin
        if (mul_en && !pen) begin
            en_rises++;
            if (pfin) stale_viol++;
        end
        pen  <= mul_en;
        pfin <= mul_finish;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_mul_en"}, 64'(mul_en), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_mul_x0"}, 64'(mul_x == '0), 64'd1);
        chk({tag, "_mul_y0"}, 64'(mul_y == '0), 64'd1);
        chk({tag, "_prod0"}, 64'(out_data), 64'd0);
    endtask

    task automatic send(input logic [W_OP-1:0] x, input logic [W_OP-1:0] y,
                        output int last_c);
        last_c = 0;
        for (int k = 0; k < 2 * N_IN; k++) begin
            int t;
            in_valid = 1'b1;
            in_data  = (k < N_IN) ? x[k*W_WORD +: W_WORD]
                                  : y[(k-N_IN)*W_WORD +: W_WORD];
            t = 0;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                chk("send_ready_timeout", 64'(k), 64'hFFFF);
                in_valid = 1'b0;
                return;
            end
            last_c = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic recv(input logic [W_PROD-1:0] exp, input int stall_at,
                        input bit rnd, input string tag);
        for (int j = 0; j < N_OUT; j++) begin
            int t = 0;
            while (!out_valid && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (!out_valid) begin
                chk({tag, "_valid_timeout"}, 64'(j), 64'hFFFF);
                return;
            end
            if (j == 0) first_cyc = cyc;
            if (j == stall_at) begin
                for (int s = 0; s < 10; s++) begin
                    @(negedge clk);
                    chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
                    chk({tag, "_hold_data"}, 64'(out_data),
                        64'(exp[j*W_WORD +: W_WORD]));
                    chk({tag, "_hold_last"}, 64'(out_last), 64'(j == N_OUT - 1));
                end
            end
            if (rnd) begin
                while ($urandom_range(3) == 0) @(negedge clk);
            end
            chk({tag, "_data"}, 64'(out_data), 64'(exp[j*W_WORD +: W_WORD]));
            chk({tag, "_last"}, 64'(out_last), 64'(j == N_OUT - 1));
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk({tag, "_done_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_done_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done_ready"}, 64'(in_ready), 64'd1);
    endtask

    typedef struct {
        logic [W_OP-1:0]   x;
        logic [W_OP-1:0]   y;
        logic [W_PROD-1:0] p;
        int                l;
        int                stall;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lc;
        logic [W_OP-1:0]   rx, ry;
        logic [W_PROD-1:0] rp;

        tbl[0] = '{x: 1024'd3, y: 1024'd5, p: 2048'd15, l: 5, stall: -1};
        tbl[1] = '{x: {W_OP{1'b1}}, y: {W_OP{1'b1}},
                   p: {{31{32'hFFFFFFFF}}, 32'hFFFFFFFE, {31{32'h0}}, 32'h1},
                   l: 3, stall: 10};
        tbl[2] = '{x: 1024'd1, y: {W_OP{1'b1}}, p: {{W_OP{1'b0}}, {W_OP{1'b1}}},
                   l: 1, stall: -1};
        tbl[3] = '{x: 1024'd0, y: 1024'hDEADBEEF, p: 2048'd0, l: 2, stall: 0};
        tbl[4] = '{x: 1024'd1 << 1023, y: 1024'd2, p: 2048'd1 << 1024,
                   l: 6, stall: 63};
        tbl[5] = '{x: 1024'hFFFFFFFF, y: 1024'h100000001,
                   p: 2048'hFFFFFFFF_FFFFFFFF, l: 4, stall: -1};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("rst_held");
        rst = 1'b0;
        @(negedge clk);
        chk_reset("rst_rel");

        for (int i = 0; i < 6; i++) begin
            stub_l = tbl[i].l;
            send(tbl[i].x, tbl[i].y, lc);
            chk($sformatf("v%0d_mul_x", i), 64'(mul_x == tbl[i].x), 64'd1);
            chk($sformatf("v%0d_mul_y", i), 64'(mul_y == tbl[i].y), 64'd1);
            recv(tbl[i].p, tbl[i].stall, 1'b0, $sformatf("v%0d", i));
            chk($sformatf("v%0d_latency", i), 64'(first_cyc - lc),
                64'(tbl[i].l + 3));
        end

        // Stale finish: first job leaves finish high well into the next FIRE.
        stub_l = 4;
        stub_hold = 200;
        send(1024'd7, 1024'd9, lc);
        recv(2048'd63, -1, 1'b0, "stale_a");
        send(1024'd11, 1024'd13, lc);
        repeat (2) @(negedge clk);
        chk("stale_fin_high", 64'(mul_finish), 64'd1);
        chk("stale_en_low", 64'(mul_en), 64'd0);
        chk("stale_busy", 64'(busy), 64'd1);
        chk("stale_in_ready", 64'(in_ready), 64'd0);
        recv(2048'd143, -1, 1'b0, "stale_b");
        stub_hold = 0;

        // Reset after one X word.
        in_valid = 1'b1;
        in_data = 32'h12345678;
        @(negedge clk);
        in_valid = 1'b0;
        chk("partial_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1 chk_reset("rst_load");
        @(negedge clk);
        rst = 1'b0;

        // Reset while the third product word is presented.
        stub_l = 2;
        send({W_OP{1'b1}}, 1024'd3, lc);
        begin
            int t = 0;
            while (!out_valid && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("drain_rst_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        chk("drain_rst_word2", 64'(out_data), 64'hFFFFFFFF);
        #2 rst = 1'b1;
        #1 chk_reset("rst_drain");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(1024'd1000, 1024'd1000, lc);
        recv(2048'd1000000, -1, 1'b0, "post_rst");
        chk("post_rst_latency", 64'(first_cyc - lc), 64'd5);

        // Random jobs checked against plain multiplication.
        for (int n = 0; n < 14; n++) begin
            int l;
            for (int w = 0; w < N_IN; w++) begin
                rx[w*W_WORD +: W_WORD] = $urandom();
                ry[w*W_WORD +: W_WORD] = $urandom();
            end
            if (n % 5 == 1) rx = rx >> $urandom_range(1000);
            if (n % 5 == 3) ry = {W_OP{1'b1}};
            rp = {{W_OP{1'b0}}, rx} * {{W_OP{1'b0}}, ry};
            l = $urandom_range(6, 1);
            stub_l = l;
            stub_hold = $urandom_range(3);
            send(rx, ry, lc);
            recv(rp, -1, 1'b1, $sformatf("rnd%0d", n));
            chk($sformatf("rnd%0d_latency", n), 64'(first_cyc - lc), 64'(l + 3));
        end
        stub_hold = 0;

`ifdef KARAT_SEQ_TIMEOUT_EN
        begin
            int en_cnt = 0;
            int t = 0;
            stub_never = 1'b1;
            send(1024'd5, 1024'd6, lc);
            while (!err && t < 100) begin
                if (mul_en) en_cnt++;
                @(negedge clk);
                t++;
            end
            chk("to_err_set", 64'(err), 64'd1);
            chk("to_wait_cycles", 64'(en_cnt), 64'(TO_CYC));
            chk("to_en_dropped", 64'(mul_en), 64'd0);
            recv(2048'd0, 2, 1'b0, "to_zero");
            chk("to_err_sticky", 64'(err), 64'd1);
            stub_never = 1'b0;
            stub_l = 3;
            send(1024'd2, 1024'd21, lc);
            recv(2048'd42, -1, 1'b0, "to_after");
            chk("to_err_still", 64'(err), 64'd1);
            @(negedge clk);
            rst = 1'b1;
            #1 chk("to_err_cleared", 64'(err), 64'd0);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
        end
`else
        chk("err_tied_low", 64'(err), 64'd0);
`endif

        chk("en_rises_seen", 64'(en_rises > 20), 64'd1);
        chk("stale_en_viol", 64'(stale_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
